inst_fetch_buffer: RTL and testbench

- Small instruction FIFO between the AXI read adapter (fetch side) and the decode stage.
- Absorbs instruction beats (inst, address) while decode is stalled.
- Produces the ready/full feedback the adapter uses to pace fetch requests.
- Drops flushed beats, so decode never sees a killed instruction.

---
 rtl/inst_fetch_buffer.sv | 103 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: instruction FIFO between the AXI read adapter and decode.
// Ports: clk, reset (sync, active-high), flush; in_valid/in_inst/in_pc/in_ready
// from the adapter; out_valid/out_inst/out_pc/out_ready to decode; full, count.
// Optional FETCH_BUF_BYPASS_EN: empty-buffer beats pass straight to decode.
module inst_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_pc,
    output logic              in_ready,
    output logic              full,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [31:0]       inst_q [DEPTH];
    logic [31:0]       pc_q   [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_nxt;
    logic              full_q;
    logic              stored;
    logic              byp;
    logic              push;
    logic              pop;

    assign stored   = (count_q != '0);
    assign in_ready = flush | (count_q < CNT_MAX);

`ifdef FETCH_BUF_BYPASS_EN
    assign byp = ~stored & in_valid & (in_pc != '0) & ~flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed beat taken by decode is never written.
    // Zero-address beats are acknowledged but dropped.
    assign push = in_valid & in_ready & ~flush & ~reset
                & (in_pc != '0) & ~(byp & out_ready);
    assign pop  = stored & out_ready & ~flush;

    assign out_valid = stored | byp;
    assign full      = full_q;
    assign count     = count_q;

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        if (stored) begin
            out_inst = inst_q[rd_ptr];
            out_pc   = pc_q[rd_ptr];
        end else if (byp) begin
            out_inst = in_inst;
            out_pc   = in_pc;
        end
    end

    always_comb begin
        count_nxt = count_q;
        if (reset || flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_nxt;
        // Registered near-full keeps a slot for the adapter's in-flight read.
        full_q  <= (count_nxt >= CNT_FULL);
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= in_inst;
            pc_q[wr_ptr]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed self-checking bench for inst_fetch_buffer.
// Drives beats, flush and reset; checks outputs against hand-computed values.
module tb_inst_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        full;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    inst_fetch_buffer #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .full      (full),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] i,
                        input logic [31:0] p);
        in_valid = v;
        in_inst  = i;
        in_pc    = p;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_oinst", out_inst, 0);
        chk("rst_opc", out_pc, 0);
        chk("rst_full", full, 0);
        chk("rst_iready", in_ready, 1);

        // single beat
        beat(1'b1, 32'h24020005, 32'hBFC00000);
        out_ready = 1'b1;
        #1;
`ifdef FETCH_BUF_BYPASS_EN
        chk("t1_byp_ovalid", out_valid, 1);
        chk("t1_byp_opc", out_pc, 32'hBFC00000);
        tick;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_byp_count", count, 0);
`else
        chk("t1_pre_ovalid", out_valid, 0);
        tick;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("t1_ovalid", out_valid, 1);
        chk("t1_oinst", out_inst, 32'h24020005);
        chk("t1_opc", out_pc, 32'hBFC00000);
        chk("t1_count1", count, 1);
        tick;
        chk("t1_count0", count, 0);
        chk("t1_ovalid0", out_valid, 0);
        chk("t1_opc0", out_pc, 0);
`endif

        // fill with decode stalled
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 32'h10000000 + i, 32'hBFC00000 + 4 * i);
            #1;
            chk("fill_iready", in_ready, 1);
            tick;
            chk("fill_count", count, i + 1);
            chk("fill_full", full, (i + 1 >= 3) ? 1 : 0);
        end
        beat(1'b1, 32'h10000004, 32'hBFC00010);
        #1;
        chk("fill_iready_full", in_ready, 0);
        tick;
        chk("fill_held_count", count, 4);
        beat(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_opc", out_pc, 32'hBFC00000 + 4 * i);
            chk("drain_oinst", out_inst, 32'h10000000 + i);
            tick;
        end
        chk("drain_count", count, 0);
        chk("drain_ovalid", out_valid, 0);
        chk("drain_full", full, 0);

        // count=3 with wr_ptr=3, then push+pop twice across the wrap
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 32'hA0000000 + i, 32'h80000000 + 4 * i);
            tick;
        end
        chk("pp_count_pre", count, 3);
        chk("pp_full_pre", full, 1);
        out_ready = 1'b1;
        beat(1'b1, 32'hA0000003, 32'h8000000C);
        #1;
        chk("pp_head0", out_pc, 32'h80000000);
        tick;
        chk("pp_count1", count, 3);
        chk("pp_head1", out_pc, 32'h80000004);
        beat(1'b1, 32'hA0000004, 32'h80000010);
        tick;
        chk("pp_count2", count, 3);
        chk("pp_head2", out_pc, 32'h80000008);
        chk("pp_head2_inst", out_inst, 32'hA0000002);

        // flush with count=3 and a beat presented
        out_ready = 1'b0;
        flush     = 1'b1;
        beat(1'b1, 32'hDEADBEEF, 32'h90000000);
        #1;
        chk("fl_iready", in_ready, 1);
        tick;
        flush = 1'b0;
        beat(1'b1, 32'h0, 32'h0);
        #1;
        chk("fl_count", count, 0);
        chk("fl_ovalid", out_valid, 0);
        chk("fl_full", full, 0);
        chk("z_iready", in_ready, 1);
        tick;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("z_count", count, 0);
        chk("z_ovalid", out_valid, 0);

        // reset mid-stream with count=2
        beat(1'b1, 32'hC0000000, 32'hB0000000);
        tick;
        beat(1'b1, 32'hC0000001, 32'hB0000004);
        tick;
        chk("rs_count_pre", count, 2);
        reset = 1'b1;
        beat(1'b1, 32'hC0000002, 32'hB0000008);
        tick;
        reset = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("rs_count", count, 0);
        chk("rs_ovalid", out_valid, 0);
        chk("rs_opc", out_pc, 0);
        chk("rs_iready", in_ready, 1);
        chk("rs_full", full, 0);

        // empty buffer, decode ready
        out_ready = 1'b1;
        beat(1'b1, 32'h24030007, 32'hBFC00010);
        #1;
`ifdef FETCH_BUF_BYPASS_EN
        chk("bp_ovalid", out_valid, 1);
        chk("bp_opc", out_pc, 32'hBFC00010);
        chk("bp_oinst", out_inst, 32'h24030007);
        tick;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("bp_count", count, 0);
        chk("bp_ovalid_after", out_valid, 0);
`else
        chk("nb_ovalid_now", out_valid, 0);
        tick;
        beat(1'b0, 32'h0, 32'h0);
        #1;
        chk("nb_ovalid", out_valid, 1);
        chk("nb_opc", out_pc, 32'hBFC00010);
        chk("nb_oinst", out_inst, 32'h24030007);
        tick;
        chk("nb_count", count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
